// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared opcode field positions, END encoding and sequencer state codes
package gpu_pkg;

   localparam int OPC_CLASS_HI = 15;
   localparam int OPC_CLASS_LO = 14;
   localparam logic [1:0] CLASS_CTRL = 2'b11;
   localparam int END_SEL_BIT  = 8;
   localparam int END_FLAG_BIT = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // END is a control-class word with the select bit clear and the flag bit set
   function automatic logic is_end_word(input logic [15:0] w);
      return (w[OPC_CLASS_HI:OPC_CLASS_LO] == CLASS_CTRL) && !w[END_SEL_BIT] && w[END_FLAG_BIT];
   endfunction

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - instruction store, synchronous write and combinational read, never reset
module prog_mem #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);

   logic [15:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - runs the stored program once per start, broadcasting one opcode per cycle
module program_sequencer
   import gpu_pkg::*;
#(
   parameter int PROG_DEPTH = 32,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   input  logic              start,
   input  logic              hold,
   output logic [15:0]       opcode,
   output logic              execute,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   issued
);

   localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_DEPTH - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       opcode_q, opcode_d;
   logic              execute_q, execute_d;
   logic [ADDR_W:0]   issued_q, issued_d;
   logic [15:0]       mem_rdata;
   logic              mem_we;

   // Program is frozen while a run is in flight so the cores see a consistent stream
   assign mem_we = prog_we && (state_q == ST_IDLE) && !rst;

   prog_mem #(
      .DEPTH  (PROG_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      execute_d = 1'b0;
      issued_d  = issued_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               pc_d     = '0;
               issued_d = '0;
            end
         end
         ST_RUN: begin
            if (!hold) begin
               if (is_end_word(mem_rdata)) begin
                  state_d = ST_DONE;
               end else begin
                  opcode_d  = mem_rdata;
                  execute_d = 1'b1;
                  issued_d  = issued_q + 1'b1;
                  // Last slot ends the run implicitly; pc parks instead of wrapping
                  if (pc_q == PC_LAST) begin
                     state_d = ST_DONE;
                  end else begin
                     pc_d = pc_q + 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         opcode_q  <= 16'h0000;
         execute_q <= 1'b0;
         issued_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         execute_q <= execute_d;
         issued_q  <= issued_d;
      end
   end

   assign opcode  = opcode_q;
   assign execute = execute_q;
   assign issued  = issued_q;
   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);

endmodule
